// File: rtl/mbist_march_gen.sv
// March C- address/data sequencer for MBIST: walks six march elements over a
// single-port synchronous RAM, compares read data one cycle later and flags the first failure.
module mbist_march_gen #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld,
    input  logic              NbarT,
    input  logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] wdata,
    output logic              we,
    output logic              re,
    output logic              cout,
    output logic              fail,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [2:0]        dbg_elem
);

    // Handshake: ld has priority and re-initialises; NbarT=1 issues exactly one
    // march op per cycle (NbarT=0 pauses); rdata is valid the cycle after re=1.
    typedef enum logic [2:0] {
        E0_UP_W0   = 3'd0,
        E1_UP_R0W1 = 3'd1,
        E2_UP_R1W0 = 3'd2,
        E3_DN_R0W1 = 3'd3,
        E4_DN_R1W0 = 3'd4,
        E5_UP_R0   = 3'd5
    } elem_t;

    elem_t             r_elem;
    logic              r_op;
    logic [ADDR_W-1:0] r_addr;
    logic              r_rd_pend;
    logic [DATA_W-1:0] r_exp;
    logic [ADDR_W-1:0] r_a_q;
    logic              r_fail;
    logic [ADDR_W-1:0] r_fail_addr;

    elem_t             w_elem_nxt;
    logic              w_op_nxt;
    logic [ADDR_W-1:0] w_addr_nxt;
    logic              w_down;
    logic              w_last_op;
    logic              w_last_addr;
    logic              w_is_read;
    logic              w_run;
    logic              w_wr_one;
    logic              w_rd_one;

    always_comb begin
        w_down      = (r_elem == E3_DN_R0W1) || (r_elem == E4_DN_R1W0);
        w_last_op   = ((r_elem == E0_UP_W0) || (r_elem == E5_UP_R0)) ? 1'b1 : r_op;
        w_last_addr = w_down ? (r_addr == '0) : (r_addr == '1);
        w_is_read   = (r_elem != E0_UP_W0) && !r_op;
        w_wr_one    = (r_elem == E1_UP_R0W1) || (r_elem == E3_DN_R0W1);
        w_rd_one    = (r_elem == E2_UP_R1W0) || (r_elem == E4_DN_R1W0);
        // Reset also forces the strobes low so the RAM sees no op while rst is held.
        w_run       = NbarT && !ld && !rst;
    end

    assign addr      = r_addr;
    assign we        = w_run && !w_is_read;
    assign re        = w_run && w_is_read;
    assign wdata     = we ? {DATA_W{w_wr_one}} : '0;
    assign cout      = w_run && (r_elem == E5_UP_R0) && (r_addr == '1) && w_last_op;
    assign fail      = r_fail;
    assign fail_addr = r_fail_addr;
    assign dbg_elem  = r_elem;

    always_comb begin
        w_elem_nxt = r_elem;
        w_op_nxt   = r_op;
        w_addr_nxt = r_addr;
        if (ld) begin
            w_elem_nxt = E0_UP_W0;
            w_op_nxt   = 1'b0;
            w_addr_nxt = '0;
        end else if (NbarT) begin
            if (!w_last_op) begin
                w_op_nxt = 1'b1;
            end else begin
                w_op_nxt = 1'b0;
                if (!w_last_addr) begin
                    w_addr_nxt = w_down ? r_addr - 1'b1 : r_addr + 1'b1;
                end else if (r_elem == E5_UP_R0) begin
                    w_elem_nxt = E0_UP_W0;
                    w_addr_nxt = '0;
                end else begin
                    w_elem_nxt = elem_t'(r_elem + 3'd1);
                    w_addr_nxt = ((w_elem_nxt == E3_DN_R0W1) || (w_elem_nxt == E4_DN_R1W0)) ? '1 : '0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_elem <= E0_UP_W0;
            r_op   <= 1'b0;
            r_addr <= '0;
        end else begin
            r_elem <= w_elem_nxt;
            r_op   <= w_op_nxt;
            r_addr <= w_addr_nxt;
        end
    end

    // Read check pipeline; the sticky flag keeps only the first failing address.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_pend   <= 1'b0;
            r_exp       <= '0;
            r_a_q       <= '0;
            r_fail      <= 1'b0;
            r_fail_addr <= '0;
        end else if (ld) begin
            r_rd_pend   <= 1'b0;
            r_fail      <= 1'b0;
            r_fail_addr <= '0;
        end else begin
            r_rd_pend <= re;
            if (re) begin
                r_exp <= {DATA_W{w_rd_one}};
                r_a_q <= r_addr;
            end
            if (r_rd_pend && (rdata != r_exp)) begin
                r_fail <= 1'b1;
                if (!r_fail) begin
                    r_fail_addr <= r_a_q;
                end
            end
        end
    end

endmodule

// File: tb/tb_mbist_march_gen.sv
// Directed bench for mbist_march_gen: March C- op stream against a scoreboard built
// from the element table, with a fault-injectable synchronous RAM model.
module tb_mbist_march_gen;
    localparam int AW = 2;
    localparam int DW = 8;
    localparam int VW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          ld;
    logic          NbarT;
    logic [DW-1:0] rdata;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          we;
    logic          re;
    logic          cout;
    logic          fail;
    logic [AW-1:0] fail_addr;
    logic [2:0]    dbg_elem;

    logic [VW-1:0] exp_q[$];
    int n_vec = 0;
    int n_err = 0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    mbist_march_gen #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst), .ld(ld), .NbarT(NbarT), .rdata(rdata),
        .addr(addr), .wdata(wdata), .we(we), .re(re), .cout(cout),
        .fail(fail), .fail_addr(fail_addr), .dbg_elem(dbg_elem)
    );

    // ---------------- RAM model with per-word stuck-at masks ----------------
    logic [DW-1:0] mem   [4];
    logic [DW-1:0] and_m [4];
    logic [DW-1:0] or_m  [4];

    always @(posedge clk) begin
        if (we) mem[addr] <= wdata;
        if (re) rdata <= (mem[addr] & and_m[addr]) | or_m[addr];
    end

    // ---------------- scoreboard ----------------
    function automatic logic [VW-1:0] obs_vec();
        return {dbg_elem, cout, we, re, addr, wdata};
    endfunction

    task automatic check(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic load_march();
        int            nops_t [6] = '{1, 2, 2, 2, 2, 1};
        bit            down_t [6] = '{0, 0, 0, 1, 1, 0};
        logic [DW-1:0] wr_t   [6] = '{8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'h00};
        logic [AW-1:0] a;
        logic          is_rd;
        exp_q.delete();
        for (int e = 0; e < 6; e++)
            for (int k = 0; k < 4; k++)
                for (int o = 0; o < nops_t[e]; o++) begin
                    a     = down_t[e] ? AW'(3 - k) : AW'(k);
                    is_rd = (e != 0) && (o == 0);
                    exp_q.push_back({3'(e), (e == 5) && (k == 3), !is_rd, is_rd, a,
                                     is_rd ? 8'h00 : wr_t[e]});
                end
    endtask

    // ---------------- driver tasks (enter and leave at posedge+1) ----------------
    task automatic do_ld();
        ld = 1'b1;
        NbarT = 1'b0;
        @(negedge clk);
        check("ld_strobes", obs_vec() & 16'h1CFF, 16'h0000);
        @(posedge clk); #1;
        ld = 1'b0;
        @(negedge clk);
        check("ld_state", obs_vec(), 16'h0000);
        check("ld_fail", {13'b0, fail, fail_addr}, 16'h0000);
        @(posedge clk); #1;
    endtask

    task automatic run_ops(input int n, input int pause_at, input int pause_len);
        logic [VW-1:0] v;
        for (int i = 0; i < n; i++) begin
            if (i == pause_at) begin
                NbarT = 1'b0;
                for (int p = 0; p < pause_len; p++) begin
                    @(negedge clk);
                    v = exp_q[0];
                    check($sformatf("pause%0d", p), obs_vec(), {v[15:13], 3'b000, v[9:8], 8'h00});
                    @(posedge clk); #1;
                end
            end
            NbarT = 1'b1;
            @(negedge clk);
            v = exp_q.pop_front();
            check($sformatf("op%0d", i), obs_vec(), v);
            @(posedge clk); #1;
        end
        NbarT = 1'b0;
    endtask

    task automatic check_fail(input string tag, input logic f, input logic [AW-1:0] fa, input bit wrapped);
        @(negedge clk);
        check(tag, {13'b0, fail, fail_addr}, {13'b0, f, fa});
        if (wrapped) check({tag, "_wrap"}, obs_vec(), 16'h0000);
        @(posedge clk); #1;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst = 1'b1; ld = 1'b0; NbarT = 1'b0; rdata = '0;
        for (int i = 0; i < 4; i++) begin
            and_m[i] = 8'hFF; or_m[i] = 8'h00; mem[i] = 8'h00;
        end
        #1;
        check("reset_out", obs_vec(), 16'h0000);
        check("reset_fail", {13'b0, fail, fail_addr}, 16'h0000);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Clean full run: 40 ops, cout only on the last, no failure.
        do_ld(); load_march(); run_ops(40, -1, 0);
        check_fail("clean_fail", 1'b0, 2'd0, 1'b1);

        // Stuck-at-0 bit0 at word 2: first caught by E2 r1 of address 2.
        and_m[2] = 8'hFE;
        do_ld(); load_march(); run_ops(40, -1, 0);
        check_fail("sa0_a2", 1'b1, 2'd2, 1'b1);
        and_m[2] = 8'hFF;

        // Pause five cycles inside E2, then finish.
        do_ld(); load_march(); run_ops(40, 15, 5);
        check_fail("pause_fail", 1'b0, 2'd0, 1'b1);

        // Stuck-at-1 at word 1 seen in E1, then ld together with NbarT.
        or_m[1] = 8'h01;
        do_ld(); load_march(); run_ops(10, -1, 0);
        check_fail("sa1_a1", 1'b1, 2'd1, 1'b0);
        ld = 1'b1; NbarT = 1'b1;
        @(negedge clk);
        check("ld_nbart_strobes", obs_vec() & 16'h1CFF, 16'h0000);
        @(posedge clk); #1;
        ld = 1'b0; NbarT = 1'b0;
        @(negedge clk);
        check("ld_nbart_state", obs_vec(), 16'h0000);
        check("ld_nbart_fail", {13'b0, fail, fail_addr}, 16'h0000);
        @(posedge clk); #1;
        or_m[1] = 8'h00;

        // Two faults: the first failing address is held, ld clears it.
        and_m[1] = 8'hFE; and_m[3] = 8'hFE;
        do_ld(); load_march(); run_ops(40, -1, 0);
        check_fail("two_faults", 1'b1, 2'd1, 1'b1);
        do_ld();

        // Async reset mid-test with a failure latched and NbarT high.
        load_march(); run_ops(20, -1, 0);
        check_fail("pre_rst_fail", 1'b1, 2'd1, 1'b0);
        NbarT = 1'b1;
        #2 rst = 1'b1;
        #1;
        check("async_rst_out", obs_vec(), 16'h0000);
        check("async_rst_fail", {13'b0, fail, fail_addr}, 16'h0000);
        @(posedge clk); #1;
        rst = 1'b0; NbarT = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
